// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IF/ID/EX/MEM/WB control FSM for the multi-cycle MIPS datapath with memory-ready handshake
module multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mem_rdy,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_op,
  output logic [2:0] alu_ctr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       mem_to_reg,
  output logic [1:0] pc_src,
  output logic       ovf_flag,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state_o
);
  typedef enum logic [3:0] {
    S_IF, S_ID, S_EXR, S_EXI, S_EXMA, S_EXBR, S_EXJ,
    S_MRD, S_MWR, S_WBR, S_WBI, S_WBLW
  } state_t;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t state_q, state_d;
  logic ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] r_ctr;
  logic r_ok, wait_st, tmo;
  always_comb begin
    r_ctr = 3'b000;
    r_ok = 1'b1;
    case (funct)
      6'b100000: r_ctr = 3'b001;
      6'b100001: r_ctr = 3'b000;
      6'b100010: r_ctr = 3'b101;
      6'b100011: r_ctr = 3'b100;
      6'b100101: r_ctr = 3'b010;
      6'b101010: r_ctr = 3'b111;
      6'b101011: r_ctr = 3'b110;
      default:   r_ok = 1'b0;
    endcase
  end
  assign wait_st = state_q inside {S_IF, S_MRD, S_MWR};
  assign tmo = wait_st && !mem_rdy && (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));
  assign cnt_d = (wait_st && !mem_rdy && !tmo) ? cnt_q + 1'b1 : '0;
  assign state_o = state_q;
  always_comb begin
    state_d = S_IF;
    ovf_d = ovf_q;
    pc_wr = 1'b0;
    ir_wr = 1'b0;
    reg_wr = 1'b0;
    reg_dst = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    ext_op = 1'b0;
    alu_ctr = 3'b000;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    mem_to_reg = 1'b0;
    pc_src = 2'b00;
    ovf_flag = 1'b0;
    illegal = 1'b0;
    bus_err = 1'b0;
    case (state_q)
      S_IF: begin
        mem_rd = 1'b1;
        alu_src_b = 2'b01;
        pc_wr = mem_rdy;
        ir_wr = mem_rdy;
        ovf_d = 1'b0;
        bus_err = tmo;
        state_d = mem_rdy ? S_ID : S_IF;
      end
      S_ID: begin
        alu_src_b = 2'b11;
        ext_op = 1'b1;
        state_d = op == 6'b000000 ? (r_ok ? S_EXR : S_IF) :
                  op inside {6'b001101, 6'b001001, 6'b001000} ? S_EXI :
                  op inside {6'b100011, 6'b101011} ? S_EXMA :
                  op == 6'b000100 ? S_EXBR :
                  op == 6'b000010 ? S_EXJ : S_IF;
        illegal = state_d == S_IF;
      end
      S_EXR: begin
        alu_src_a = 1'b1;
        alu_ctr = r_ctr;
        ovf_d = overflow;
        state_d = S_WBR;
      end
      S_EXI: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op = op != 6'b001101;
        alu_ctr = op == 6'b001101 ? 3'b010 : op == 6'b001000 ? 3'b001 : 3'b000;
        ovf_d = overflow;
        state_d = S_WBI;
      end
      S_EXMA: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op = 1'b1;
        state_d = op == 6'b101011 ? S_MWR : S_MRD;
      end
      S_EXBR: begin
        alu_src_a = 1'b1;
        alu_ctr = 3'b100;
        pc_src = 2'b01;
        pc_wr = zero;
      end
      S_EXJ: begin
        pc_src = 2'b10;
        pc_wr = 1'b1;
      end
      S_MRD: begin
        mem_rd = 1'b1;
        bus_err = tmo;
        state_d = mem_rdy ? S_WBLW : tmo ? S_IF : S_MRD;
      end
      S_MWR: begin
        mem_wr = 1'b1;
        bus_err = tmo;
        state_d = (mem_rdy || tmo) ? S_IF : S_MWR;
      end
      S_WBR, S_WBI: begin
        reg_dst = state_q == S_WBR;
        reg_wr = ~ovf_q;
        ovf_flag = ovf_q;
      end
      S_WBLW: begin
        mem_to_reg = 1'b1;
        reg_wr = 1'b1;
      end
      default: state_d = S_IF;
    endcase
    if (rst) begin
      pc_wr = 1'b0;
      ir_wr = 1'b0;
      reg_wr = 1'b0;
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      ovf_flag = 1'b0;
      illegal = 1'b0;
      bus_err = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
